res_port_arbiter: RTL

Arbitrates the single-port result RAM (`res_*` bus, 16384 x 8) between up to NREQ pass engines of the distance-transform datapath (e.g. initialize, forward pass, backward pass, and any later debug/readout engine). Each engine requests ownership, holds it for a burst of reads and writes, and releases it. Read data is returned with a per-requester valid strobe. The block sits between the pass engines and the top-level `res_*` pins, replacing the phase-indexed output mux.

---
 rtl/res_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/res_port_arbiter.sv
// Result-RAM port arbiter: round-robin ownership grant for NREQ pass engines
// with direct handoff, optional hold-limit preemption and per-requester read return.
module res_port_arbiter #(
   parameter int unsigned NREQ     = 3,
   parameter int unsigned AW       = 14,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_HOLD = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_i,
   output logic [NREQ-1:0]    gnt_o,
   input  logic [NREQ-1:0]    rd_i,
   input  logic [NREQ-1:0]    wr_i,
   input  logic [NREQ*AW-1:0] addr_i,
   input  logic [NREQ*DW-1:0] wdata_i,
   output logic [DW-1:0]      rdata_o,
   output logic [NREQ-1:0]    rvalid_o,
   output logic               res_rd_o,
   output logic               res_wr_o,
   output logic [AW-1:0]      res_addr_o,
   output logic [DW-1:0]      res_do_o,
   input  logic [DW-1:0]      res_di_i,
   output logic               err_o
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW = IW + 1;

   typedef enum logic [0:0] {StIdle, StOwned} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   own_q, own_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [15:0]     hold_q, hold_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;
   logic            err_q, err_d;

   logic [IW-1:0]     own_inc;
   logic [IW-1:0]     scan_start;
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              scan_found;
   logic [SW-1:0]     scan_sum;
   logic [IW-1:0]     scan_idx;
   logic              owner_req;
   logic              others_pending;
   logic              preempt;

   assign own_inc        = (32'(own_q) == NREQ - 1) ? '0 : own_q + 1'b1;
   assign owner_req      = |(req_i & gnt_q);
   assign others_pending = |(req_i & ~gnt_q);
   assign preempt        = (MAX_HOLD != 0) && (state_q == StOwned) && owner_req &&
                           others_pending && (hold_q == 16'(MAX_HOLD - 1));

   // Round-robin scan: rotate requests so the start index sits at bit 0, take the first set bit.
   always_comb begin
      scan_start = (state_q == StOwned) ? own_inc : ptr_q;
      req_dbl    = {req_i, req_i} >> scan_start;
      req_rot    = req_dbl[NREQ-1:0];
      scan_found = 1'b0;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!scan_found && req_rot[k]) begin
            scan_found = 1'b1;
            scan_sum   = SW'(scan_start) + SW'(k);
            if (scan_sum >= SW'(NREQ)) begin
               scan_sum = scan_sum - SW'(NREQ);
            end
            scan_idx = scan_sum[IW-1:0];
         end
      end
   end

   // Ownership FSM: grant from idle, hold, release/preempt with same-edge handoff.
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         StIdle: begin
            if (scan_found) begin
               state_d         = StOwned;
               own_d           = scan_idx;
               hold_d          = '0;
               gnt_d           = '0;
               gnt_d[scan_idx] = 1'b1;
            end
         end
         StOwned: begin
            if (!owner_req || preempt) begin
               ptr_d  = own_inc;
               hold_d = '0;
               gnt_d  = '0;
               if (scan_found) begin
                  own_d           = scan_idx;
                  gnt_d[scan_idx] = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else if ((MAX_HOLD != 0) && others_pending) begin
               hold_d = hold_q + 16'd1;
            end else begin
               hold_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   // RAM bus is driven only by an owner that still holds its request; read wins only without write.
   always_comb begin
      res_rd_o   = 1'b0;
      res_wr_o   = 1'b0;
      res_addr_o = '0;
      res_do_o   = '0;
      if ((state_q == StOwned) && owner_req) begin
         res_addr_o = addr_i[own_q*AW +: AW];
         res_do_o   = wdata_i[own_q*DW +: DW];
         res_wr_o   = wr_i[own_q];
         res_rd_o   = rd_i[own_q] & ~wr_i[own_q];
      end
   end

   // Read return is tagged with the issuing owner, so it survives a handoff on the same edge.
   always_comb begin
      rvalid_d = '0;
      if (res_rd_o) begin
         rvalid_d[own_q] = 1'b1;
      end
      err_d = err_q | (|(rd_i & wr_i & gnt_q)) | (|((rd_i | wr_i) & ~gnt_q));
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         own_q    <= '0;
         ptr_q    <= '0;
         hold_q   <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         own_q    <= own_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign gnt_o    = gnt_q;
   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = res_di_i;

endmodule
